// File: rtl/cadr_spc_pkg.sv
// cadr_spc_pkg: shared SPC stack constants, op encoding and entry layout
package cadr_spc_pkg;
  localparam int PC_BITS = 14;
  localparam int SPC_BITS = 19;
  localparam int PTR_BITS = 5;
  typedef enum logic [1:0] {OP_NONE, OP_PUSH_CALL, OP_PUSH_L, OP_POP} spc_op_e;
  // Call entry: return address in the low bits, ret_flag just above, zero pad on top.
  function automatic logic [SPC_BITS-1:0] call_entry(input logic ret_flag, input logic [PC_BITS-1:0] lpc);
    return {{(SPC_BITS-PC_BITS-1){1'b0}}, ret_flag, lpc};
  endfunction
endpackage

// File: rtl/spc_depth_tracker.sv
// spc_depth_tracker: SPC stack depth counter with sticky overflow/underflow flags
// Ports: clk, reset; inc/dec one-cycle update requests; depth 0..2**PTR_BITS; ovf/unf sticky.
module spc_depth_tracker
  import cadr_spc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              dec,
  output logic [PTR_BITS:0] depth,
  output logic              ovf,
  output logic              unf
);
  localparam logic [PTR_BITS:0] FULL = {1'b1, {PTR_BITS{1'b0}}};
  // Saturating: a push at full or a pop at empty leaves depth alone and raises a flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      depth <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (inc && depth == FULL) ovf <= 1'b1;
      if (dec && depth == '0) unf <= 1'b1;
      if (inc && depth != FULL) depth <= depth + 1'b1;
      if (dec && depth != '0) depth <= depth - 1'b1;
    end
  end
endmodule

// File: rtl/spc_ctl.sv
// spc_ctl: SPC stack control, turning call/popj/destspc requests into phased stack strobes
// Ports: clk, reset; state_alu/write/fetch phase strobes; call_req/popj_req/destspc_req with
// lpc, ret_flag, l; spco read data. Outputs spcnt/spush/srp/swp/spcw strobes and data,
// popj_pc/popj_valid return address, depth and sticky spc_ovf/spc_unf/spc_conflict.
module spc_ctl
  import cadr_spc_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                state_alu,
  input  logic                state_write,
  input  logic                state_fetch,
  input  logic                call_req,
  input  logic                popj_req,
  input  logic                destspc_req,
  input  logic [PC_BITS-1:0]  lpc,
  input  logic                ret_flag,
  input  logic [SPC_BITS-1:0] l,
  input  logic [SPC_BITS-1:0] spco,
  output logic                spcnt,
  output logic                spush,
  output logic                srp,
  output logic                swp,
  output logic [SPC_BITS-1:0] spcw,
  output logic [PC_BITS-1:0]  popj_pc,
  output logic                popj_valid,
  output logic [PTR_BITS:0]   depth,
  output logic                spc_ovf,
  output logic                spc_unf,
  output logic                spc_conflict
);
  spc_op_e op, op_n;
  logic [SPC_BITS-1:0] spcw_n;
  logic [PC_BITS-1:0] pc_q;
  logic push, pop;
  always_comb begin
    op_n = op;
    spcw_n = spcw;
    if (state_alu) begin
      op_n = call_req ? OP_PUSH_CALL : destspc_req ? OP_PUSH_L : popj_req ? OP_POP : OP_NONE;
      spcw_n = call_req ? call_entry(ret_flag, lpc) : destspc_req ? l : '0;
    end else if (state_fetch) begin
      op_n = OP_NONE;
      spcw_n = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      op <= OP_NONE;
      spcw <= '0;
      pc_q <= '0;
      spc_conflict <= 1'b0;
    end else begin
      op <= op_n;
      spcw <= spcw_n;
      if (state_alu && ((call_req & popj_req) | (call_req & destspc_req) | (popj_req & destspc_req)))
        spc_conflict <= 1'b1;
      if (popj_valid) pc_q <= spco[PC_BITS-1:0];
    end
  end
  assign push = op == OP_PUSH_CALL || op == OP_PUSH_L;
  assign pop = op == OP_POP;
  assign spcnt = push | pop;
  assign spush = push;
  assign swp = push & state_write;
  assign srp = pop & state_write;
  assign popj_valid = pop & state_fetch;
  // Pass the RAM read data straight through in fetch so the return address is usable there.
  assign popj_pc = popj_valid ? spco[PC_BITS-1:0] : pc_q;
  spc_depth_tracker u_depth (
    .clk   (clk),
    .reset (reset),
    .inc   (push & state_fetch),
    .dec   (pop & state_fetch),
    .depth (depth),
    .ovf   (spc_ovf),
    .unf   (spc_unf)
  );
endmodule
